// File: rtl/aes_pkg.sv
// Shared AES byte arithmetic and column types for the serial MixColumns datapath.
package aes_pkg;

  localparam int         BYTES_PER_COL = 4;
  localparam logic [7:0] AES_REDUCE    = 8'h1B;

  // b0 lives in the top byte so a column reads left-to-right in stream order.
  typedef logic [31:0] col_word_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_REDUCE : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns matrix applied to one 32-bit column (b0 in bits 31:24).
module mix_column_word
  import aes_pkg::*;
(
  input  col_word_t col_i,
  output col_word_t col_o
);

  logic [7:0] b0, b1, b2, b3;

  assign {b0, b1, b2, b3} = col_i;

  assign col_o = {xtime(b0) ^ gmul3(b1) ^ b2        ^ b3,
                  b0        ^ xtime(b1) ^ gmul3(b2) ^ b3,
                  b0        ^ b1        ^ xtime(b2) ^ gmul3(b3),
                  gmul3(b0) ^ b1        ^ b2        ^ xtime(b3)};

endmodule

// File: rtl/mix_columns_serial.sv
// Byte-serial MixColumns: buffers each 4-byte column, mixes it on the 4th byte and
// streams the result back out one byte per clock, with a final-round bypass.
module mix_columns_serial
  import aes_pkg::*;
#(
  parameter int NCOLS     = 4,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inBits,
  input  logic       in_valid,
  input  logic       last_round,
  output logic [7:0] outBits,
  output logic       out_valid,
  output logic       block_last
);

  localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;

  logic [1:0]                          byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]                       col_cnt_q, col_cnt_d;
  logic [BYTES_PER_COL-2:0][7:0]       buf_q, buf_d;
  logic [23:0]                         out_sr_q, out_sr_d;
  logic [7:0]                          out_byte_q, out_byte_d;
  logic                                out_vld_q, out_vld_d;
  logic                                blk_last_q, blk_last_d;
  logic [1:0]                          out_cnt_q, out_cnt_d;
  logic                                last_col_q, last_col_d;

  logic      col_done;
  col_word_t col_word, mixed, result;

  // The 4th byte bypasses the buffer so the column is mixed on the edge it arrives.
  assign col_done = in_valid && (byte_cnt_q == 2'd3);
  assign col_word = {buf_q[0], buf_q[1], buf_q[2], inBits};

  mix_column_word u_mix (
    .col_i (col_word),
    .col_o (mixed)
  );

  assign result = (BYPASS_EN && last_round) ? col_word : mixed;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    col_cnt_d  = col_cnt_q;
    buf_d      = buf_q;
    out_sr_d   = out_sr_q;
    out_byte_d = out_byte_q;
    out_vld_d  = out_vld_q;
    blk_last_d = blk_last_q;
    out_cnt_d  = out_cnt_q;
    last_col_d = last_col_q;

    if (in_valid) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    buf_d[0] = inBits;
        2'd1:    buf_d[1] = inBits;
        2'd2:    buf_d[2] = inBits;
        default: ;
      endcase
    end

    // A fresh column load wins over retiring the previous one's last byte.
    if (col_done) begin
      col_cnt_d  = (col_cnt_q == CW'(NCOLS - 1)) ? '0 : col_cnt_q + 1'b1;
      last_col_d = (col_cnt_q == CW'(NCOLS - 1));
      out_byte_d = result[31:24];
      out_sr_d   = result[23:0];
      out_vld_d  = 1'b1;
      blk_last_d = 1'b0;
      out_cnt_d  = 2'd3;
    end else if (out_cnt_q != 2'd0) begin
      out_byte_d = out_sr_q[23:16];
      out_sr_d   = {out_sr_q[15:0], 8'h00};
      out_cnt_d  = out_cnt_q - 2'd1;
      blk_last_d = (out_cnt_q == 2'd1) && last_col_q;
    end else begin
      out_vld_d  = 1'b0;
      blk_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      col_cnt_q  <= '0;
      buf_q      <= '0;
      out_sr_q   <= '0;
      out_byte_q <= '0;
      out_vld_q  <= 1'b0;
      blk_last_q <= 1'b0;
      out_cnt_q  <= '0;
      last_col_q <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      col_cnt_q  <= col_cnt_d;
      buf_q      <= buf_d;
      out_sr_q   <= out_sr_d;
      out_byte_q <= out_byte_d;
      out_vld_q  <= out_vld_d;
      blk_last_q <= blk_last_d;
      out_cnt_q  <= out_cnt_d;
      last_col_q <= last_col_d;
    end
  end

  assign outBits    = out_byte_q;
  assign out_valid  = out_vld_q;
  assign block_last = blk_last_q;

endmodule
